// File: rtl/wb_stream_arbiter_if.sv
// Bundle of all request, response and shared-port signals of wb_stream_arbiter.
// The arbiter connects through the slave modport: it takes the stream
// controllers' requests and the memory's responses, and drives the shared
// port, the routed responses and the grant. The surrounding system
// (controllers plus memory) uses the master modport.
interface wb_stream_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int WB_AW       = 32,
  parameter int WB_DW       = 32
);
  logic [NUM_MASTERS*WB_AW-1:0]     wbs_adr_i;
  logic [NUM_MASTERS*WB_DW-1:0]     wbs_dat_i;
  logic [NUM_MASTERS*WB_DW/8-1:0]   wbs_sel_i;
  logic [NUM_MASTERS-1:0]           wbs_we_i;
  logic [NUM_MASTERS-1:0]           wbs_cyc_i;
  logic [NUM_MASTERS-1:0]           wbs_stb_i;
  logic [NUM_MASTERS*3-1:0]         wbs_cti_i;
  logic [NUM_MASTERS*2-1:0]         wbs_bte_i;
  logic [WB_DW-1:0]                 wbs_dat_o;
  logic [NUM_MASTERS-1:0]           wbs_ack_o;
  logic [NUM_MASTERS-1:0]           wbs_err_o;
  logic [NUM_MASTERS-1:0]           wbs_rty_o;

  logic [WB_AW-1:0]                 wbm_adr_o;
  logic [WB_DW-1:0]                 wbm_dat_o;
  logic [WB_DW/8-1:0]               wbm_sel_o;
  logic                             wbm_we_o;
  logic                             wbm_cyc_o;
  logic                             wbm_stb_o;
  logic [2:0]                       wbm_cti_o;
  logic [1:0]                       wbm_bte_o;
  logic [WB_DW-1:0]                 wbm_dat_i;
  logic                             wbm_ack_i;
  logic                             wbm_err_i;
  logic                             wbm_rty_i;

  logic [NUM_MASTERS-1:0]           grant_o;

  modport slave (
    input  wbs_adr_i, wbs_dat_i, wbs_sel_i, wbs_we_i, wbs_cyc_i, wbs_stb_i,
    input  wbs_cti_i, wbs_bte_i,
    output wbs_dat_o, wbs_ack_o, wbs_err_o, wbs_rty_o,
    output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
    output wbm_cti_o, wbm_bte_o,
    input  wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i,
    output grant_o
  );

  modport master (
    output wbs_adr_i, wbs_dat_i, wbs_sel_i, wbs_we_i, wbs_cyc_i, wbs_stb_i,
    output wbs_cti_i, wbs_bte_i,
    input  wbs_dat_o, wbs_ack_o, wbs_err_o, wbs_rty_o,
    input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
    input  wbm_cti_o, wbm_bte_o,
    output wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i,
    input  grant_o
  );
endinterface

// File: rtl/wb_stream_arbiter.sv
// Round-robin Wishbone B3 arbiter: NUM_MASTERS stream controllers share one
// master port. A grant lasts for the whole cyc of the winner, so bursts are
// never split, and an optional watchdog aborts a slave that stalls too long.
//
// state   | meaning
// S_IDLE  | no owner; shared port idle; pick next requester round-robin
// S_GRANT | owner's signals passed through, responses routed to owner only
// S_ABORT | watchdog fired; shared port forced idle until owner drops cyc
module wb_stream_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int WB_AW       = 32,
  parameter int WB_DW       = 32,
  parameter int TIMEOUT     = 0
) (
  input logic               wb_clk_i,
  input logic               wb_rst_n_i,
  wb_stream_arbiter_if.slave bus
);
  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SW = WB_DW / 8;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_ABORT} state_t;

  state_t                 state;
  logic [IW-1:0]          grant_idx;
  logic [IW-1:0]          last_idx;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [CW-1:0]          wd_cnt;

  logic [IW-1:0]          winner;
  logic                   rr_found;
  int                     rr_cand;
  logic                   any_req;
  logic                   g_cyc;
  logic                   g_stb;
  logic                   slv_resp;
  logic                   wd_hit;
  logic                   fwd;

  logic [WB_AW-1:0]       m_adr [NUM_MASTERS];
  logic [WB_DW-1:0]       m_dat [NUM_MASTERS];
  logic [SW-1:0]          m_sel [NUM_MASTERS];
  logic [2:0]             m_cti [NUM_MASTERS];
  logic [1:0]             m_bte [NUM_MASTERS];

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
    assign m_adr[g] = bus.wbs_adr_i[g*WB_AW +: WB_AW];
    assign m_dat[g] = bus.wbs_dat_i[g*WB_DW +: WB_DW];
    assign m_sel[g] = bus.wbs_sel_i[g*SW +: SW];
    assign m_cti[g] = bus.wbs_cti_i[g*3 +: 3];
    assign m_bte[g] = bus.wbs_bte_i[g*2 +: 2];
  end

  assign any_req  = |bus.wbs_cyc_i;
  assign g_cyc    = bus.wbs_cyc_i[grant_idx];
  assign g_stb    = bus.wbs_stb_i[grant_idx];
  assign slv_resp = bus.wbm_ack_i | bus.wbm_err_i | bus.wbm_rty_i;
  // Reset is gated in so nothing leaks out while wb_rst_n_i is held low.
  assign fwd      = wb_rst_n_i && (state == S_GRANT);

  // The abort fires on the stalled cycle that completes TIMEOUT; a slave
  // response arriving in that same cycle takes precedence.
  if (TIMEOUT > 0) begin : g_wd
    assign wd_hit = (state == S_GRANT) && g_stb && !slv_resp &&
                    (wd_cnt == CW'(TIMEOUT - 1));
  end else begin : g_no_wd
    assign wd_hit = 1'b0;
  end

  // Round-robin search: first requester after the last winner, with wrap.
  always_comb begin
    winner   = last_idx;
    rr_found = 1'b0;
    rr_cand  = 0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      rr_cand = (int'(last_idx) + k) % NUM_MASTERS;
      if (!rr_found && bus.wbs_cyc_i[IW'(rr_cand)]) begin
        winner   = IW'(rr_cand);
        rr_found = 1'b1;
      end
    end
  end

  // Arbitration FSM with grant bookkeeping and stall watchdog.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state     <= S_IDLE;
      grant_idx <= '0;
      last_idx  <= IW'(NUM_MASTERS - 1);
      grant_q   <= '0;
      wd_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          wd_cnt <= '0;
          if (any_req) begin
            grant_idx <= winner;
            last_idx  <= winner;
            grant_q   <= NUM_MASTERS'(1) << winner;
            state     <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (!g_cyc) begin
            state   <= S_IDLE;
            grant_q <= '0;
            wd_cnt  <= '0;
          end else if (wd_hit) begin
            state  <= S_ABORT;
            wd_cnt <= '0;
          end else if (!g_stb || slv_resp || (TIMEOUT == 0)) begin
            wd_cnt <= '0;
          end else begin
            wd_cnt <= wd_cnt + CW'(1);
          end
        end
        S_ABORT: begin
          wd_cnt <= '0;
          if (!g_cyc) begin
            state   <= S_IDLE;
            grant_q <= '0;
          end
        end
        default: begin
          state   <= S_IDLE;
          grant_q <= '0;
          wd_cnt  <= '0;
        end
      endcase
    end
  end

  // Shared-port mux and response routing; everything idles outside S_GRANT.
  always_comb begin
    bus.wbm_adr_o = '0;
    bus.wbm_dat_o = '0;
    bus.wbm_sel_o = '0;
    bus.wbm_we_o  = 1'b0;
    bus.wbm_cyc_o = 1'b0;
    bus.wbm_stb_o = 1'b0;
    bus.wbm_cti_o = 3'b000;
    bus.wbm_bte_o = 2'b00;
    bus.wbs_ack_o = '0;
    bus.wbs_err_o = '0;
    bus.wbs_rty_o = '0;
    if (fwd) begin
      bus.wbm_adr_o = m_adr[grant_idx];
      bus.wbm_dat_o = m_dat[grant_idx];
      bus.wbm_sel_o = m_sel[grant_idx];
      bus.wbm_we_o  = bus.wbs_we_i[grant_idx];
      bus.wbm_cyc_o = g_cyc;
      bus.wbm_stb_o = g_stb;
      bus.wbm_cti_o = m_cti[grant_idx];
      bus.wbm_bte_o = m_bte[grant_idx];
      bus.wbs_ack_o[grant_idx] = bus.wbm_ack_i;
      bus.wbs_err_o[grant_idx] = bus.wbm_err_i | wd_hit;
      bus.wbs_rty_o[grant_idx] = bus.wbm_rty_i;
    end
  end

  assign bus.wbs_dat_o = bus.wbm_dat_i;
  assign bus.grant_o   = wb_rst_n_i ? grant_q : '0;
endmodule

// File: tb/tb_wb_stream_arbiter.sv
// Bench for wb_stream_arbiter: directed scenarios with literal expectations,
// then randomized masters and slave, all checked each cycle against a
// behavioural owner/round-robin model.
module tb_wb_stream_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  wb_stream_arbiter_if #(.NUM_MASTERS(N), .WB_AW(AW), .WB_DW(DW)) bus ();

  wb_stream_arbiter #(.NUM_MASTERS(N), .WB_AW(AW), .WB_DW(DW), .TIMEOUT(TO)) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .bus        (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_time_limit reached: got running expected finished");
    $fatal(1, "time limit");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int  m_owner = -1;   // index of the master owning the port, -1 if none
  bit  m_abort = 1'b0; // owner was cut off by the watchdog
  int  m_last  = N - 1;
  int  m_stall = 0;    // consecutive stalled strobe cycles of the owner

  logic [AW-1:0]   e_adr;
  logic [DW-1:0]   e_dat;
  logic [DW/8-1:0] e_sel;
  logic            e_we, e_cyc, e_stb, e_to;
  logic [2:0]      e_cti;
  logic [1:0]      e_bte;
  logic [N-1:0]    e_ack, e_err, e_rty, e_grant;
  int              eo;

  always_comb begin
    e_adr = '0; e_dat = '0; e_sel = '0; e_we = 1'b0; e_cyc = 1'b0; e_stb = 1'b0;
    e_cti = 3'b000; e_bte = 2'b00; e_ack = '0; e_err = '0; e_rty = '0;
    e_grant = '0; e_to = 1'b0; eo = 0;
    if (rst_n && m_owner >= 0) begin
      eo = m_owner;
      e_grant[eo] = 1'b1;
      if (!m_abort) begin
        e_adr = bus.wbs_adr_i[eo*AW +: AW];
        e_dat = bus.wbs_dat_i[eo*DW +: DW];
        e_sel = bus.wbs_sel_i[eo*(DW/8) +: DW/8];
        e_we  = bus.wbs_we_i[eo];
        e_cyc = bus.wbs_cyc_i[eo];
        e_stb = bus.wbs_stb_i[eo];
        e_cti = bus.wbs_cti_i[eo*3 +: 3];
        e_bte = bus.wbs_bte_i[eo*2 +: 2];
        e_to  = e_stb && !(bus.wbm_ack_i || bus.wbm_err_i || bus.wbm_rty_i) &&
                (m_stall == TO - 1);
        e_ack[eo] = bus.wbm_ack_i;
        e_err[eo] = bus.wbm_err_i || e_to;
        e_rty[eo] = bus.wbm_rty_i;
      end
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      m_owner = -1; m_abort = 1'b0; m_last = N - 1; m_stall = 0;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (m_owner < 0 && bus.wbs_cyc_i[c]) m_owner = c;
      end
      if (m_owner >= 0) begin
        m_last  = m_owner;
        m_stall = 0;
      end
    end else if (!bus.wbs_cyc_i[m_owner]) begin
      m_owner = -1; m_abort = 1'b0; m_stall = 0;
    end else if (!m_abort) begin
      if (e_to) begin
        m_abort = 1'b1; m_stall = 0;
      end else if (bus.wbs_stb_i[m_owner] &&
                   !(bus.wbm_ack_i || bus.wbm_err_i || bus.wbm_rty_i)) begin
        m_stall++;
      end else begin
        m_stall = 0;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    check("wbm_adr", bus.wbm_adr_o, e_adr);
    check("wbm_dat", bus.wbm_dat_o, e_dat);
    check("wbm_sel", bus.wbm_sel_o, e_sel);
    check("wbm_we",  bus.wbm_we_o,  e_we);
    check("wbm_cyc", bus.wbm_cyc_o, e_cyc);
    check("wbm_stb", bus.wbm_stb_o, e_stb);
    check("wbm_cti", bus.wbm_cti_o, e_cti);
    check("wbm_bte", bus.wbm_bte_o, e_bte);
    check("wbs_ack", bus.wbs_ack_o, e_ack);
    check("wbs_err", bus.wbs_err_o, e_err);
    check("wbs_rty", bus.wbs_rty_o, e_rty);
    check("grant",   bus.grant_o,   e_grant);
    check("wbs_dat", bus.wbs_dat_o, bus.wbm_dat_i);
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m(input int i, input bit cyc, input bit stb,
                         input logic [2:0] cti, input logic [31:0] adr);
    bus.wbs_adr_i[i*AW +: AW]         = adr;
    bus.wbs_dat_i[i*DW +: DW]         = adr ^ 32'hA5A5_0000;
    bus.wbs_sel_i[i*(DW/8) +: DW/8]   = 4'hF;
    bus.wbs_we_i[i]                   = (i % 2) == 1;
    bus.wbs_cyc_i[i]                  = cyc;
    bus.wbs_stb_i[i]                  = stb;
    bus.wbs_cti_i[i*3 +: 3]           = cti;
    bus.wbs_bte_i[i*2 +: 2]           = 2'b00;
  endtask

  task automatic set_resp(input bit a, input bit e, input bit r);
    bus.wbm_ack_i = a;
    bus.wbm_err_i = e;
    bus.wbm_rty_i = r;
  endtask

  task automatic release_m(input int i);
    drive_m(i, 1'b0, 1'b0, 3'b000, 32'h0);
    step();
  endtask

  task automatic wait_grant(input string nm, input logic [N-1:0] expv);
    int k;
    k = 0;
    @(negedge clk);
    while (bus.grant_o == '0 && k < 10) begin
      @(negedge clk);
      k++;
    end
    check(nm, bus.grant_o, expv);
  endtask

  bit act [N];
  int beats [N];
  int cd [N];
  bit got_r [N];
  bit got_e [N];
  int dead_left;

  initial begin
    rst_n = 1'b0;
    bus.wbs_adr_i = '0; bus.wbs_dat_i = '0; bus.wbs_sel_i = '0; bus.wbs_we_i = '0;
    bus.wbs_cyc_i = '0; bus.wbs_stb_i = '0; bus.wbs_cti_i = '0; bus.wbs_bte_i = '0;
    bus.wbm_dat_i = 32'h1234_5678;
    set_resp(0, 0, 0);
    repeat (3) step();
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_grant", bus.grant_o, 4'b0000);
    check("reset_cyc", bus.wbm_cyc_o, 1'b0);
    check("reset_ack", bus.wbs_ack_o, 4'b0000);

    // master0 4-beat burst with acks every cycle
    step();
    drive_m(0, 1, 1, 3'b010, 32'h100);
    @(negedge clk);
    check("t1_latency_cyc", bus.wbm_cyc_o, 1'b0);
    for (int b = 0; b < 4; b++) begin
      step();
      drive_m(0, 1, 1, (b == 3) ? 3'b111 : 3'b010, 32'h100 + 32'(4 * b));
      set_resp(1, 0, 0);
      @(negedge clk);
      check("t1_ack", bus.wbs_ack_o, 4'b0001);
      check("t1_grant", bus.grant_o, 4'b0001);
      check("t1_cti", bus.wbm_cti_o, (b == 3) ? 3'b111 : 3'b010);
      check("t1_adr", bus.wbm_adr_o, 32'h100 + 32'(4 * b));
    end
    step();
    set_resp(0, 0, 0);
    drive_m(0, 0, 0, 3'b000, 32'h0);
    @(negedge clk);
    check("t1_drop_cyc", bus.wbm_cyc_o, 1'b0);
    step();
    @(negedge clk);
    check("t1_idle_grant", bus.grant_o, 4'b0000);

    // reset, then masters 0 and 1 request together
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    drive_m(0, 1, 1, 3'b000, 32'h200);
    drive_m(1, 1, 1, 3'b000, 32'h300);
    step();
    set_resp(1, 0, 0);
    @(negedge clk);
    check("t2_first_grant", bus.grant_o, 4'b0001);
    check("t2_ack_m0_only", bus.wbs_ack_o, 4'b0001);
    step();
    set_resp(0, 0, 0);
    drive_m(0, 0, 0, 3'b000, 32'h0);
    @(negedge clk);
    check("t2_drop_cyc", bus.wbm_cyc_o, 1'b0);
    step();
    drive_m(0, 1, 1, 3'b000, 32'h204);
    @(negedge clk);
    check("t2_gap_cyc", bus.wbm_cyc_o, 1'b0);
    check("t2_gap_grant", bus.grant_o, 4'b0000);
    step();
    @(negedge clk);
    check("t3_fair_m1", bus.grant_o, 4'b0010);
    check("t3_m1_cyc", bus.wbm_cyc_o, 1'b1);
    check("t3_m1_adr", bus.wbm_adr_o, 32'h300);
    release_m(1);
    wait_grant("t3_fair_m0", 4'b0001);
    step();
    release_m(0);

    // four-master order after last winner 2
    drive_m(2, 1, 1, 3'b000, 32'h400);
    wait_grant("t3_m2", 4'b0100);
    step();
    release_m(2);
    drive_m(0, 1, 1, 3'b000, 32'h500);
    drive_m(2, 1, 1, 3'b000, 32'h600);
    drive_m(3, 1, 1, 3'b000, 32'h700);
    wait_grant("t3_order_3", 4'b1000);
    step();
    release_m(3);
    wait_grant("t3_order_0", 4'b0001);
    step();
    release_m(0);
    wait_grant("t3_order_2", 4'b0100);
    step();
    release_m(2);

    // watchdog: slave silent
    drive_m(0, 1, 1, 3'b000, 32'h800);
    wait_grant("t4_grant", 4'b0001);
    check("t4_err_stall1", bus.wbs_err_o, 4'b0000);
    for (int k = 2; k <= 8; k++) begin
      step();
      @(negedge clk);
      check((k < 8) ? "t4_err_early" : "t4_err_pulse", bus.wbs_err_o,
            (k < 8) ? 4'b0000 : 4'b0001);
    end
    step();
    drive_m(1, 1, 1, 3'b000, 32'h900);
    set_resp(1, 0, 0);
    @(negedge clk);
    check("t4_abort_cyc", bus.wbm_cyc_o, 1'b0);
    check("t4_late_ack", bus.wbs_ack_o, 4'b0000);
    check("t4_abort_grant", bus.grant_o, 4'b0001);
    check("t4_err_once", bus.wbs_err_o, 4'b0000);
    step();
    set_resp(0, 0, 0);
    @(negedge clk);
    check("t4_abort_hold", bus.wbm_cyc_o, 1'b0);
    step();
    release_m(0);
    wait_grant("t4_m1_after", 4'b0010);

    // err and rty during master1 burst
    step();
    set_resp(0, 1, 0);
    @(negedge clk);
    check("t5_err", bus.wbs_err_o, 4'b0010);
    step();
    set_resp(0, 0, 1);
    @(negedge clk);
    check("t5_rty", bus.wbs_rty_o, 4'b0010);
    check("t5_grant_kept", bus.grant_o, 4'b0010);
    step();
    set_resp(1, 0, 0);
    @(negedge clk);
    check("t5_ack", bus.wbs_ack_o, 4'b0010);
    step();
    set_resp(0, 0, 0);
    release_m(1);

    // reset in the middle of a burst
    drive_m(0, 1, 1, 3'b010, 32'hA00);
    wait_grant("t6_grant", 4'b0001);
    step();
    set_resp(1, 0, 0);
    @(negedge clk);
    check("t6_beat1", bus.wbs_ack_o, 4'b0001);
    step();
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_ack_dropped", bus.wbs_ack_o, 4'b0000);
    check("t6_grant_rst", bus.grant_o, 4'b0000);
    step();
    rst_n = 1'b1;
    set_resp(0, 0, 0);
    drive_m(1, 1, 1, 3'b000, 32'hB00);
    @(negedge clk);
    check("t6_cyc_after", bus.wbm_cyc_o, 1'b0);
    check("t6_grant_after", bus.grant_o, 4'b0000);
    step();
    @(negedge clk);
    check("t6_m0_first", bus.grant_o, 4'b0001);
    step();
    for (int i = 0; i < N; i++) drive_m(i, 0, 0, 3'b000, 32'h0);
    step();
    step();

    // randomized traffic
    for (int i = 0; i < N; i++) begin
      act[i] = 0; beats[i] = 0; cd[i] = 0;
    end
    dead_left = 0;
    repeat (3000) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        got_r[i] = e_ack[i] || e_err[i] || e_rty[i];
        got_e[i] = e_err[i];
      end
      @(posedge clk);
      #1;
      rst_n = ($urandom_range(0, 399) != 0);
      for (int i = 0; i < N; i++) begin
        if (act[i]) begin
          if (got_r[i]) beats[i]--;
          if (got_e[i] || beats[i] <= 0) begin
            act[i] = 0;
            cd[i]  = $urandom_range(0, 3);
          end
        end else if (cd[i] > 0) begin
          cd[i]--;
        end else if ($urandom_range(0, 3) == 0) begin
          act[i]   = 1;
          beats[i] = $urandom_range(1, 6);
        end
        drive_m(i, act[i], act[i] && ($urandom_range(0, 7) != 0),
                (beats[i] == 1) ? 3'b111 : 3'b010, $urandom);
        bus.wbs_we_i[i] = 1'($urandom_range(0, 1));
        bus.wbs_sel_i[i*(DW/8) +: DW/8] = 4'($urandom_range(0, 15));
        bus.wbs_bte_i[i*2 +: 2] = 2'($urandom_range(0, 3));
      end
      bus.wbm_dat_i = $urandom;
      #1;
      set_resp(0, 0, 0);
      if (e_stb && dead_left == 0 && $urandom_range(0, 2) != 0) begin
        case ($urandom_range(0, 9))
          8:       set_resp(0, 1, 0);
          9:       set_resp(0, 0, 1);
          default: set_resp(1, 0, 0);
        endcase
      end
      if (dead_left > 0) dead_left--;
      else if ($urandom_range(0, 59) == 0) dead_left = 20;
    end
    step();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
